// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the fetch path
package cpu_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI   = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0;
  localparam logic [31:0] BUBBLE_PC    = 32'h0;
  localparam logic [4:0]  BUBBLE_EXC   = EXC_NONE;
  localparam logic        BUBBLE_BD    = 1'b0;

  function automatic logic fetch_addr_err(input logic [31:0] addr,
                                          input logic [31:0] lo,
                                          input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fd_reg.sv
// rtl/fd_reg.sv - F/D pipeline register with clear-over-enable priority
module fd_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [4:0]  exc,
  input  logic        bd,
  output logic [31:0] instr_q,
  output logic [31:0] pc_q,
  output logic [4:0]  exc_q,
  output logic        bd_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= BUBBLE_INSTR;
      pc_q    <= BUBBLE_PC;
      exc_q   <= BUBBLE_EXC;
      bd_q    <= BUBBLE_BD;
    end else if (clr) begin
      instr_q <= BUBBLE_INSTR;
      pc_q    <= BUBBLE_PC;
      exc_q   <= BUBBLE_EXC;
      bd_q    <= BUBBLE_BD;
    end else if (en) begin
      instr_q <= instr;
      pc_q    <= pc;
      exc_q   <= exc;
      bd_q    <= bd;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection, AdEL check and F/D register
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = cpu_pkg::PC_RESET,
  parameter logic [31:0] IMEM_LO  = cpu_pkg::IMEM_LO,
  parameter logic [31:0] IMEM_HI  = cpu_pkg::IMEM_HI
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] npc,
  input  logic        intreq,
  input  logic        eret,
  input  logic        br_in_d,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        flush;
  logic        adel_f;
  logic [31:0] instr_f;
  logic [4:0]  exc_f;

  assign flush  = intreq | eret;
  assign adel_f = fetch_addr_err(pc, IMEM_LO, IMEM_HI);

  // A faulting fetch enters D as a nop so only the exception code carries meaning.
  assign instr_f = adel_f ? 32'h0 : imem_rdata;
  assign exc_f   = adel_f ? EXC_ADEL : EXC_NONE;

  always_comb begin
    pc_next = pc + 32'd4;
    if (flush) begin
      pc_next = npc;
    end else if (stall) begin
      pc_next = pc;
    end else if (redirect) begin
      pc_next = npc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

  fd_reg u_fd_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (!stall),
    .clr     (flush),
    .instr   (instr_f),
    .pc      (pc),
    .exc     (exc_f),
    .bd      (br_in_d),
    .instr_q (instr_d),
    .pc_q    (pc_d),
    .exc_q   (exc_d),
    .bd_q    (bd_d)
  );

  assign imem_addr = pc;
  assign pc_f      = pc;
  assign pc8_d     = pc_d + 32'd8;

endmodule
